// File: rtl/beta_trap_ctrl.sv
// Trap control unit: arbitrates interrupts, exceptions and MRET, tracks the
// hart privilege level, produces the trap CSR write and the fetch redirect.

package beta_trap_ctrl_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned AddrWidth = 32;

  // Subset of CSR regfile state the trap unit consumes
  typedef struct packed {
    logic                 mie;
    logic                 mpie;
    logic                 mpp;
    logic [AddrWidth-1:0] mtvec;
    logic [AddrWidth-1:0] mepc;
    logic [DataWidth-1:0] mcause;
    logic [DataWidth-1:0] mtval;
    logic [1:0]           ext_int;
    logic [1:0]           tim_int;
    logic [1:0]           soft_int;
  } csr_ctrl_t;

endpackage

module beta_trap_ctrl #(
  parameter int unsigned DataWidth = beta_trap_ctrl_pkg::DataWidth,
  parameter int unsigned AddrWidth = beta_trap_ctrl_pkg::AddrWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  beta_trap_ctrl_pkg::csr_ctrl_t csr_control_i,
  input  logic                          exc_valid_i,
  input  logic [3:0]                    exc_cause_i,
  input  logic [DataWidth-1:0]          exc_tval_i,
  input  logic [AddrWidth-1:0]          exc_pc_i,
  input  logic                          mret_i,
  input  logic                          int_ok_i,
  input  logic [AddrWidth-1:0]          int_pc_i,
  output logic                          event_ack_o,
  output logic                          busy_o,
  output logic                          tcu_csr_we_o,
  output logic [DataWidth-1:0]          csr_mcause_o,
  output logic [DataWidth-1:0]          csr_mtval_o,
  output logic [AddrWidth-1:0]          csr_mepc_o,
  output logic [2:0]                    csr_trap_state_o,
  output logic [1:0]                    priv_lvl_o,
  output logic                          flush_o,
  output logic                          redirect_valid_o,
  output logic [AddrWidth-1:0]          redirect_pc_o,
  input  logic                          redirect_ready_i
);

  localparam logic [1:0] PrivM = 2'b11;
  localparam logic [1:0] PrivU = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMMIT   = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  state_e               state_q;
  logic [1:0]           priv_q;
  logic                 we_q;
  logic                 flush_q;
  logic                 busy_q;
  logic                 rvalid_q;
  logic [DataWidth-1:0] mcause_q;
  logic [DataWidth-1:0] mtval_q;
  logic [AddrWidth-1:0] mepc_q;
  logic [2:0]           tstate_q;
  logic [AddrWidth-1:0] rpc_q;

  logic                 irq_en;
  logic                 irq_mei;
  logic                 irq_msi;
  logic                 irq_mti;
  logic                 int_take;
  logic [3:0]           int_code;
  logic                 ack;
  logic                 priv_is_m;
  logic [3:0]           exc_code;
  logic [AddrWidth-1:0] vec_base;
  logic [DataWidth-1:0] mcause_d;
  logic [DataWidth-1:0] mtval_d;
  logic [AddrWidth-1:0] mepc_d;
  logic [2:0]           tstate_d;
  logic [AddrWidth-1:0] rpc_d;
  logic [1:0]           priv_d;

  // Event arbitration and trap-entry / trap-return value computation
  always_comb begin
    irq_en    = csr_control_i.mie | (priv_q == PrivU);
    irq_mei   = &csr_control_i.ext_int;
    irq_msi   = &csr_control_i.soft_int;
    irq_mti   = &csr_control_i.tim_int;
    priv_is_m = (priv_q == PrivM);
    int_take  = int_ok_i & irq_en & (irq_mei | irq_msi | irq_mti);
    int_code  = irq_mei ? 4'd11 : (irq_msi ? 4'd3 : 4'd7);
    ack       = (state_q == S_IDLE) & (int_take | exc_valid_i | mret_i);
    vec_base  = {csr_control_i.mtvec[AddrWidth-1:2], 2'b00};

    exc_code  = 4'd2;
    if (exc_valid_i) begin
      exc_code = ((exc_cause_i == 4'd8) && priv_is_m) ? 4'd11 : exc_cause_i;
    end

    // MRET in M-mode is the fall-through case
    mcause_d  = csr_control_i.mcause;
    mtval_d   = csr_control_i.mtval;
    mepc_d    = csr_control_i.mepc;
    tstate_d  = {csr_control_i.mpie, 1'b1, 1'b0};
    rpc_d     = csr_control_i.mepc;
    priv_d    = csr_control_i.mpp ? PrivM : PrivU;

    if (int_take) begin
      mcause_d = {1'b1, (DataWidth-1)'(int_code)};
      mtval_d  = '0;
      mepc_d   = int_pc_i;
      tstate_d = {1'b0, csr_control_i.mie, priv_is_m};
      priv_d   = PrivM;
      rpc_d    = (csr_control_i.mtvec[1:0] == 2'b01)
               ? vec_base + (AddrWidth'(int_code) << 2) : vec_base;
    end else if (exc_valid_i || !priv_is_m) begin
      // Exception, or MRET from U-mode raised as illegal instruction
      mcause_d = DataWidth'(exc_code);
      mtval_d  = exc_valid_i ? exc_tval_i : '0;
      mepc_d   = exc_pc_i;
      tstate_d = {1'b0, csr_control_i.mie, priv_is_m};
      priv_d   = PrivM;
      rpc_d    = vec_base;
    end
  end

  assign event_ack_o = ack;

  // Trap FSM with registered outputs; payload captured at accept
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      priv_q   <= PrivM;
      we_q     <= 1'b0;
      flush_q  <= 1'b0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      mcause_q <= '0;
      mtval_q  <= '0;
      mepc_q   <= '0;
      tstate_q <= '0;
      rpc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ack) begin
            state_q  <= S_COMMIT;
            we_q     <= 1'b1;
            flush_q  <= 1'b1;
            busy_q   <= 1'b1;
            priv_q   <= priv_d;
            mcause_q <= mcause_d;
            mtval_q  <= mtval_d;
            mepc_q   <= mepc_d;
            tstate_q <= tstate_d;
            rpc_q    <= rpc_d;
          end
        end
        S_COMMIT: begin
          state_q  <= S_REDIRECT;
          we_q     <= 1'b0;
          rvalid_q <= 1'b1;
        end
        S_REDIRECT: begin
          if (rvalid_q && redirect_ready_i) begin
            state_q  <= S_IDLE;
            rvalid_q <= 1'b0;
            flush_q  <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          we_q     <= 1'b0;
          rvalid_q <= 1'b0;
          flush_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign tcu_csr_we_o     = we_q;
  assign csr_mcause_o     = mcause_q;
  assign csr_mtval_o      = mtval_q;
  assign csr_mepc_o       = mepc_q;
  assign csr_trap_state_o = tstate_q;
  assign priv_lvl_o       = priv_q;
  assign flush_o          = flush_q;
  assign redirect_valid_o = rvalid_q;
  assign redirect_pc_o    = rpc_q;

endmodule

// File: tb/tb_beta_trap_ctrl.sv
// Self-checking bench for beta_trap_ctrl: directed scenarios then random
// events compared against a rule-level reference model.

module tb_beta_trap_ctrl;

  logic                          clk;
  logic                          rst;
  beta_trap_ctrl_pkg::csr_ctrl_t csr;
  logic                          exc_valid;
  logic [3:0]                    exc_cause;
  logic [31:0]                   exc_tval;
  logic [31:0]                   exc_pc;
  logic                          mret;
  logic                          int_ok;
  logic [31:0]                   int_pc;
  logic                          ready;

  logic        ack_o, busy_o, we_o, flush_o, rvalid_o;
  logic [31:0] mcause_o, mtval_o, mepc_o, rpc_o;
  logic [2:0]  ts_o;
  logic [1:0]  priv_o;

  int n_cmp = 0;
  int n_mis = 0;
  logic [1:0] m_priv;

  typedef struct {
    logic        ack;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] mepc;
    logic [31:0] target;
    logic [2:0]  ts;
    logic [1:0]  priv;
  } exp_t;

  beta_trap_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .csr_control_i    (csr),
    .exc_valid_i      (exc_valid),
    .exc_cause_i      (exc_cause),
    .exc_tval_i       (exc_tval),
    .exc_pc_i         (exc_pc),
    .mret_i           (mret),
    .int_ok_i         (int_ok),
    .int_pc_i         (int_pc),
    .event_ack_o      (ack_o),
    .busy_o           (busy_o),
    .tcu_csr_we_o     (we_o),
    .csr_mcause_o     (mcause_o),
    .csr_mtval_o      (mtval_o),
    .csr_mepc_o       (mepc_o),
    .csr_trap_state_o (ts_o),
    .priv_lvl_o       (priv_o),
    .flush_o          (flush_o),
    .redirect_valid_o (rvalid_o),
    .redirect_pc_o    (rpc_o),
    .redirect_ready_i (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: apply the trap rules to the current inputs and model privilege
  function automatic exp_t model();
    exp_t e;
    int   code;
    int   cause;
    logic in_m;
    logic [31:0] base;
    in_m  = (m_priv == 2'b11);
    base  = csr.mtvec - (csr.mtvec % 4);
    e.ack = 1'b1;
    code  = -1;
    if (int_ok && (csr.mie || !in_m)) begin
      if (csr.ext_int == 2'b11)       code = 11;
      else if (csr.soft_int == 2'b11) code = 3;
      else if (csr.tim_int == 2'b11)  code = 7;
    end
    if (code >= 0) begin
      e.mcause = 32'h8000_0000 + 32'(code);
      e.mtval  = 0;
      e.mepc   = int_pc;
      e.ts     = {1'b0, csr.mie, in_m};
      e.priv   = 2'b11;
      e.target = (csr.mtvec % 4 == 1) ? base + 32'(4 * code) : base;
    end else if (exc_valid || (mret && !in_m)) begin
      cause = exc_valid ? int'(exc_cause) : 2;
      if (exc_valid && cause == 8 && in_m) cause = 11;
      e.mcause = 32'(cause);
      e.mtval  = exc_valid ? exc_tval : 32'h0;
      e.mepc   = exc_pc;
      e.ts     = {1'b0, csr.mie, in_m};
      e.priv   = 2'b11;
      e.target = base;
    end else if (mret) begin
      e.mcause = csr.mcause;
      e.mtval  = csr.mtval;
      e.mepc   = csr.mepc;
      e.ts     = {csr.mpie, 1'b1, 1'b0};
      e.priv   = csr.mpp ? 2'b11 : 2'b00;
      e.target = csr.mepc;
    end else begin
      e = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b0, m_priv};
    end
    return e;
  endfunction

  task automatic clear_events();
    exc_valid = 1'b0;
    mret      = 1'b0;
    int_ok    = 1'b0;
  endtask

  // Present the driven event and follow it through COMMIT and REDIRECT
  task automatic run_txn(input int hold, input bit rst_in_redir);
    exp_t e;
    logic [31:0] pc_seen;
    e = model();
    @(negedge clk);
    chk("ack", 64'(ack_o), 64'(e.ack));
    if (!e.ack) begin
      chk("idle_busy", 64'(busy_o), 64'h0);
      clear_events();
      return;
    end
    @(posedge clk);
    #1 clear_events();
    m_priv = e.priv;
    @(negedge clk);
    chk("commit_we", 64'(we_o), 64'h1);
    chk("commit_flush", 64'(flush_o), 64'h1);
    chk("commit_busy", 64'(busy_o), 64'h1);
    chk("commit_rvalid", 64'(rvalid_o), 64'h0);
    chk("mcause", 64'(mcause_o), 64'(e.mcause));
    chk("mtval", 64'(mtval_o), 64'(e.mtval));
    chk("mepc", 64'(mepc_o), 64'(e.mepc));
    chk("trap_state", 64'(ts_o), 64'(e.ts));
    chk("priv", 64'(priv_o), 64'(e.priv));
    @(negedge clk);
    chk("redir_valid", 64'(rvalid_o), 64'h1);
    chk("redir_we", 64'(we_o), 64'h0);
    chk("redir_flush", 64'(flush_o), 64'h1);
    chk("redir_pc", 64'(rpc_o), 64'(e.target));
    pc_seen = e.target;
    for (int i = 0; i < hold; i++) begin
      exc_valid = 1'b1;
      #1 chk("busy_noack", 64'(ack_o), 64'h0);
      @(negedge clk);
      chk("hold_valid", 64'(rvalid_o), 64'h1);
      chk("hold_pc", 64'(rpc_o), 64'(pc_seen));
    end
    exc_valid = 1'b0;
    if (rst_in_redir) begin
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      m_priv = 2'b11;
      @(negedge clk);
      chk("abort_busy", 64'(busy_o), 64'h0);
      chk("abort_valid", 64'(rvalid_o), 64'h0);
      chk("abort_flush", 64'(flush_o), 64'h0);
      chk("abort_priv", 64'(priv_o), 64'h3);
      return;
    end
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    @(negedge clk);
    chk("done_busy", 64'(busy_o), 64'h0);
    chk("done_valid", 64'(rvalid_o), 64'h0);
    chk("done_flush", 64'(flush_o), 64'h0);
  endtask

  task automatic quiet_csr();
    csr = '0;
  endtask

  initial begin
    rst       = 1'b1;
    ready     = 1'b0;
    m_priv    = 2'b11;
    csr       = beta_trap_ctrl_pkg::csr_ctrl_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    exc_valid = 1'b1;
    exc_cause = 4'($urandom);
    exc_tval  = $urandom;
    exc_pc    = $urandom;
    mret      = 1'b1;
    int_ok    = 1'b1;
    int_pc    = $urandom;

    // Reset with random inputs present
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_priv", 64'(priv_o), 64'h3);
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_we", 64'(we_o), 64'h0);
    chk("rst_valid", 64'(rvalid_o), 64'h0);
    chk("rst_flush", 64'(flush_o), 64'h0);
    chk("rst_mcause", 64'(mcause_o), 64'h0);
    chk("rst_rpc", 64'(rpc_o), 64'h0);
    clear_events();
    quiet_csr();
    @(posedge clk);
    #1 rst = 1'b0;

    // M-mode illegal instruction
    @(posedge clk); #1;
    csr.mie = 1'b1; csr.mtvec = 32'h80;
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEADBEEF;
    run_txn(0, 1'b0);
    chk("ill_mcause", 64'(mcause_o), 64'h2);
    chk("ill_ts", 64'(ts_o), 64'h3);
    chk("ill_rpc", 64'(rpc_o), 64'h80);

    // MRET in M to U
    @(posedge clk); #1;
    quiet_csr();
    csr.mpie = 1'b1; csr.mpp = 1'b0; csr.mepc = 32'h400; csr.mcause = 32'h2;
    exc_pc = 32'h300; mret = 1'b1;
    run_txn(0, 1'b0);
    chk("mret_ts", 64'(ts_o), 64'h6);
    chk("mret_priv", 64'(priv_o), 64'h0);
    chk("mret_rpc", 64'(rpc_o), 64'h400);

    // U-mode vectored timer interrupt
    @(posedge clk); #1;
    quiet_csr();
    csr.mtvec = 32'h201; csr.tim_int = 2'b11;
    int_ok = 1'b1; int_pc = 32'h500;
    run_txn(0, 1'b0);
    chk("mti_mcause", 64'(mcause_o), 64'h80000007);
    chk("mti_rpc", 64'(rpc_o), 64'h21C);
    chk("mti_priv", 64'(priv_o), 64'h3);

    // Back to U, then MRET in U is illegal
    @(posedge clk); #1;
    quiet_csr(); csr.mepc = 32'h600; mret = 1'b1;
    run_txn(0, 1'b0);
    @(posedge clk); #1;
    quiet_csr(); csr.mtvec = 32'h40; mret = 1'b1; exc_pc = 32'h604;
    run_txn(0, 1'b0);
    chk("umret_mcause", 64'(mcause_o), 64'h2);
    chk("umret_mtval", 64'(mtval_o), 64'h0);

    // Interrupt beats a simultaneous ecall
    @(posedge clk); #1;
    quiet_csr(); csr.mie = 1'b1; csr.ext_int = 2'b11; csr.tim_int = 2'b11;
    int_ok = 1'b1; int_pc = 32'h700;
    exc_valid = 1'b1; exc_cause = 4'd8; exc_pc = 32'h6FC; exc_tval = 32'h0;
    run_txn(0, 1'b0);
    chk("mei_mcause", 64'(mcause_o), 64'h8000000B);

    // Ecall alone from M promotes to 11
    @(posedge clk); #1;
    quiet_csr();
    exc_valid = 1'b1; exc_cause = 4'd8; exc_pc = 32'h6FC;
    run_txn(0, 1'b0);
    chk("ecall_m", 64'(mcause_o), 64'd11);

    // Ecall from U stays 8
    @(posedge clk); #1;
    quiet_csr(); csr.mepc = 32'h800; mret = 1'b1;
    run_txn(0, 1'b0);
    @(posedge clk); #1;
    quiet_csr();
    exc_valid = 1'b1; exc_cause = 4'd8; exc_pc = 32'h804;
    run_txn(0, 1'b0);
    chk("ecall_u", 64'(mcause_o), 64'd8);

    // Ready held low three cycles, then reset inside REDIRECT
    @(posedge clk); #1;
    quiet_csr(); csr.mtvec = 32'h1000;
    exc_valid = 1'b1; exc_cause = 4'd4; exc_tval = 32'h13; exc_pc = 32'h900;
    run_txn(3, 1'b0);
    @(posedge clk); #1;
    quiet_csr(); csr.mepc = 32'hA00; mret = 1'b1;
    run_txn(1, 1'b1);

    // Random events against the model
    for (int it = 0; it < 150; it++) begin
      @(posedge clk); #1;
      csr.mie      = 1'($urandom);
      csr.mpie     = 1'($urandom);
      csr.mpp      = 1'($urandom);
      csr.mtvec    = $urandom;
      csr.mepc     = $urandom;
      csr.mcause   = $urandom;
      csr.mtval    = $urandom;
      csr.ext_int  = 2'($urandom);
      csr.tim_int  = 2'($urandom);
      csr.soft_int = 2'($urandom);
      exc_valid    = ($urandom_range(0, 2) == 0);
      exc_cause    = 4'($urandom);
      exc_tval     = $urandom;
      exc_pc       = $urandom;
      mret         = ($urandom_range(0, 2) == 0);
      int_ok       = 1'($urandom);
      int_pc       = $urandom;
      run_txn($urandom_range(0, 2), ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
